// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The master issues the address; the slave returns one word per ack.
interface fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage with IF/ID register, one-entry skid buffer and redirect handling.
// DROP waits out a request orphaned by a redirect so the bus never sees a withdrawn request.
module fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    fetch_unit_if.master       imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic [PC_W-1:0]    id_pc_next
);
    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DROP} state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    drop_addr_q;
    logic               skid_valid_q;
    logic [INSTR_W-1:0] skid_instr_q;
    logic [PC_W-1:0]    skid_pc_q;

    logic free;
    logic req;
    logic id_load;
    logic skid_to_id;
    logic skid_load;
    logic bubble;
    logic pc_inc;
    logic pc_jump;
    logic drop_cap;

    assign free           = !id_valid || !stall;
    assign imem.imem_req  = req;
    assign imem.imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req        = 1'b0;
        id_load    = 1'b0;
        skid_to_id = 1'b0;
        skid_load  = 1'b0;
        bubble     = 1'b0;
        pc_inc     = 1'b0;
        pc_jump    = 1'b0;
        drop_cap   = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                req = 1'b1;
                if (redirect) begin
                    pc_jump = 1'b1;
                    bubble  = 1'b1;
                    if (!imem.imem_ack) begin
                        state_d  = DROP;
                        drop_cap = 1'b1;
                    end
                end else if (imem.imem_ack) begin
                    pc_inc = 1'b1;
                    if (free) begin
                        id_load = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end else if (free) begin
                    bubble = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_jump = 1'b1;
                    bubble  = 1'b1;
                    state_d = FETCH;
                end else if (free && skid_valid_q) begin
                    skid_to_id = 1'b1;
                    state_d    = FETCH;
                end
            end
            DROP: begin
                req = 1'b1;
                if (redirect) begin
                    pc_jump = 1'b1;
                    bubble  = 1'b1;
                end
                if (imem.imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            drop_addr_q  <= RESET_PC;
            id_valid     <= 1'b0;
            id_instr     <= '0;
            id_pc        <= '0;
            id_pc_next   <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            if (pc_jump) begin
                pc_q <= redirect_pc;
            end else if (pc_inc) begin
                pc_q <= pc_q + PC_ONE;
            end
            if (drop_cap) begin
                drop_addr_q <= pc_q;
            end
            if (bubble) begin
                id_valid <= 1'b0;
            end else if (id_load) begin
                id_valid   <= 1'b1;
                id_instr   <= imem.imem_rdata;
                id_pc      <= pc_q;
                id_pc_next <= pc_q + PC_ONE;
            end else if (skid_to_id) begin
                id_valid   <= 1'b1;
                id_instr   <= skid_instr_q;
                id_pc      <= skid_pc_q;
                id_pc_next <= skid_pc_q + PC_ONE;
            end
            // Leaving HOLD by either path empties the skid.
            if (skid_load) begin
                skid_valid_q <= 1'b1;
                skid_instr_q <= imem.imem_rdata;
                skid_pc_q    <= pc_q;
            end else if (skid_to_id || (state_q == HOLD && pc_jump)) begin
                skid_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against
// an in-order stream model with a latency-programmable memory responder.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [7:0]  id_pc;
    logic [7:0]  id_pc_next;

    int n_tests = 0;
    int n_fail  = 0;
    int lat_mode = 0;

    fetch_unit_if #(.PC_W(8), .INSTR_W(16)) bus ();

    fetch_unit #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (bus),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_next  (id_pc_next)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {a ^ 8'hA5, ~a};
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    // Memory: each new request waits lat_mode cycles (random 0..2 if negative).
    bit   pending;
    int   wait_cnt;
    logic req_prev;
    always @(negedge clk) begin
        if (reset) begin
            pending      = 1'b0;
            wait_cnt     = 0;
            req_prev     = 1'b0;
            bus.imem_ack = 1'b0;
        end else begin
            if (bus.imem_ack && req_prev) pending = 1'b0;
            if (bus.imem_req && !pending) begin
                pending  = 1'b1;
                wait_cnt = (lat_mode < 0) ? int'($urandom_range(0, 2)) : lat_mode;
            end
            if (pending && wait_cnt == 0) begin
                bus.imem_ack = 1'b1;
            end else begin
                bus.imem_ack = 1'b0;
                if (pending) wait_cnt--;
            end
            req_prev = bus.imem_req;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string name, input logic [7:0] pc);
        logic [7:0] nx;
        nx = pc + 8'd1;
        n_tests++;
        if ({id_valid, id_pc, id_instr, id_pc_next} !== {1'b1, pc, mem_word(pc), nx}) begin
            n_fail++;
            $display("FAIL %s: got v=%b pc=%h instr=%h next=%h want v=1 pc=%h instr=%h next=%h",
                     name, id_valid, id_pc, id_instr, id_pc_next, pc, mem_word(pc), nx);
        end
    endtask

    task automatic check_bus(input string name, input logic rq, input logic [7:0] ad);
        n_tests++;
        if ({bus.imem_req, bus.imem_addr} !== {rq, ad}) begin
            n_fail++;
            $display("FAIL %s: got req=%b addr=%h want req=%b addr=%h",
                     name, bus.imem_req, bus.imem_addr, rq, ad);
        end
    endtask

    task automatic check_bubble(input string name);
        n_tests++;
        if (id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got id_valid=%b want 0", name, id_valid);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 8'h00;
        repeat (2) step();
        n_tests++;
        if ({bus.imem_req, bus.imem_addr, id_valid, id_instr, id_pc, id_pc_next} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_values: got req=%b addr=%h v=%b instr=%h pc=%h next=%h want all 0",
                     bus.imem_req, bus.imem_addr, id_valid, id_instr, id_pc, id_pc_next);
        end
    endtask

    task automatic test_zero_wait();
        lat_mode = 0;
        do_reset();
        check_bus("boot_no_req", 1'b0, 8'h00);
        step();
        check_bus("first_req", 1'b1, 8'h00);
        check_bubble("first_req_empty");
        for (int k = 0; k < 8; k++) begin
            step();
            check_id("zero_wait_seq", 8'(k));
        end
    endtask

    task automatic test_wait_states();
        lat_mode = 1;
        do_reset();
        step();
        step();
        check_bus("wait_addr_hold", 1'b1, 8'h00);
        check_bubble("wait_no_data");
        step();
        check_id("wait_first", 8'h00);
        for (int k = 1; k < 4; k++) begin
            step();
            check_bubble("wait_bubble");
            check_bus("wait_addr_stable", 1'b1, 8'(k));
            step();
            check_id("wait_seq", 8'(k));
        end
    endtask

    task automatic test_stall();
        lat_mode = 0;
        do_reset();
        repeat (6) step();
        check_id("stall_pre", 8'h04);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_id("stall_hold", 8'h04);
            check_bus("stall_no_req", 1'b0, 8'h06);
        end
        stall = 1'b0;
        for (int k = 5; k < 8; k++) begin
            step();
            check_id("stall_release", 8'(k));
        end
    endtask

    task automatic test_redirect_drop();
        lat_mode = 0;
        do_reset();
        repeat (10) step();
        check_id("drop_pre", 8'h08);
        lat_mode    = 3;
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        step();
        redirect = 1'b0;
        check_bus("drop_addr0", 1'b1, 8'h09);
        check_bubble("drop_flush");
        step();
        check_bus("drop_addr1", 1'b1, 8'h09);
        step();
        check_bus("drop_addr2", 1'b1, 8'h09);
        check_bubble("drop_discard");
        step();
        check_bus("drop_target_req", 1'b1, 8'h40);
        check_bubble("drop_still_empty");
        lat_mode = 0;
        step();
        check_id("drop_target", 8'h40);
    endtask

    task automatic test_wrap();
        redirect    = 1'b1;
        redirect_pc = 8'hFF;
        step();
        redirect = 1'b0;
        check_bubble("wrap_flush");
        step();
        check_id("wrap_ff", 8'hFF);
        step();
        check_id("wrap_00", 8'h00);
    endtask

    task automatic test_reset_mid();
        stall = 1'b1;
        step();
        n_tests++;
        if (id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre_valid: got %b want 1", id_valid);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({bus.imem_req, bus.imem_addr, id_valid, id_instr, id_pc, id_pc_next} !== 42'd0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got req=%b addr=%h v=%b instr=%h pc=%h next=%h want all 0",
                     bus.imem_req, bus.imem_addr, id_valid, id_instr, id_pc, id_pc_next);
        end
        stall = 1'b0;
        step();
        reset = 1'b0;
        check_bus("mid_boot", 1'b0, 8'h00);
        step();
        check_bus("mid_restart_req", 1'b1, 8'h00);
        step();
        check_id("mid_restart_first", 8'h00);
    endtask

    task automatic test_random();
        logic [7:0] exp_pc;
        logic       prev_req;
        logic [7:0] prev_addr;
        int         idle;
        lat_mode = -1;
        do_reset();
        step();
        exp_pc    = 8'h00;
        idle      = 0;
        prev_req  = bus.imem_req;
        prev_addr = bus.imem_addr;
        for (int c = 0; c < 400; c++) begin
            if (prev_req && !bus.imem_ack) begin
                n_tests++;
                if ({bus.imem_req, bus.imem_addr} !== {1'b1, prev_addr}) begin
                    n_fail++;
                    $display("FAIL rand_req_stable: got req=%b addr=%h want req=1 addr=%h",
                             bus.imem_req, bus.imem_addr, prev_addr);
                end
            end
            stall       = ($urandom_range(0, 99) < 30);
            redirect    = ($urandom_range(0, 99) < 5);
            redirect_pc = 8'($urandom);
            if (redirect) begin
                exp_pc = redirect_pc;
                idle   = 0;
            end else if (id_valid && !stall) begin
                check_id("rand_stream", exp_pc);
                exp_pc = exp_pc + 8'd1;
                idle   = 0;
            end else begin
                idle++;
            end
            if (idle > 40) begin
                n_tests++;
                n_fail++;
                $display("FAIL rand_progress: got %0d idle cycles want <= 40", idle);
                break;
            end
            prev_req  = bus.imem_req;
            prev_addr = bus.imem_addr;
            step();
        end
        stall    = 1'b0;
        redirect = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect_drop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
